// File: rtl/gig_eth_pkg.sv
// Shared definitions for the gigabit Ethernet receive path: frame limits,
// FSM state encodings and the output beat payload.
package gig_eth_pkg;

  localparam int unsigned MAX_FRAME_SIZE_STANDARD = 1522;
  localparam int unsigned MAX_FRAME_SIZE_JUMBO    = 9022;
  localparam int unsigned LEN_W                   = 14;
  localparam int unsigned DROP_W                  = 16;
  localparam int unsigned BYTE_W                  = 8;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_RECV = 2'd1,
    W_DROP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_SEND = 1'b1
  } rd_state_e;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [BYTE_W-1:0] data;
  } rx_beat_t;

endpackage

// File: rtl/gig_eth_sdp_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
// The read register holds its value while rd_en is low.
module gig_eth_sdp_ram #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/gig_eth_rx_frame_buf.sv
// Store-and-forward receive frame buffer: bytes are written speculatively,
// committed on goodframe, rolled back on error, and streamed out with backpressure.
module gig_eth_rx_frame_buf
  import gig_eth_pkg::*;
#(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned LEN_DEPTH = 4,
  parameter int unsigned MAX_FRAME = MAX_FRAME_SIZE_STANDARD
) (
  input  logic              rx_clk,
  input  logic              reset_n,
  input  logic [BYTE_W-1:0] mac_rx_data,
  input  logic              mac_rx_dvld,
  input  logic              mac_rx_goodframe,
  input  logic              mac_rx_badframe,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  input  logic              out_ready,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned LF_AW = (LEN_DEPTH > 1) ? $clog2(LEN_DEPTH) : 1;
  localparam int unsigned LF_CW = $clog2(LEN_DEPTH + 1);
  localparam logic [PTR_W-1:0] BUF_BYTES = PTR_W'(1) << ADDR_W;
  localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_FRAME);
  localparam logic [LF_CW-1:0] LF_SLOTS  = LF_CW'(LEN_DEPTH);
  localparam logic [LF_AW-1:0] LF_LAST   = LF_AW'(LEN_DEPTH - 1);

  wr_state_e         w_state_q, w_state_d;
  rd_state_e         r_state_q, r_state_d;
  logic [PTR_W-1:0]  wr_cur_q, wr_cur_d;
  logic [PTR_W-1:0]  wr_com_q, wr_com_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  rd_iss_q, rd_iss_d;
  logic [LEN_W-1:0]  frm_len_q, frm_len_d;
  logic [LEN_W-1:0]  rd_left_q, rd_left_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              dvld_prev_q, dvld_prev_d;
  logic [LEN_W-1:0]  lf_mem_q [LEN_DEPTH];
  logic [LEN_W-1:0]  lf_mem_d [LEN_DEPTH];
  logic [LF_AW-1:0]  lf_wr_q, lf_wr_d;
  logic [LF_AW-1:0]  lf_rd_q, lf_rd_d;
  logic [LF_CW-1:0]  lf_cnt_q, lf_cnt_d;
  logic              slot_vld_q, slot_vld_d;
  logic              slot_sop_q, slot_sop_d;
  logic              slot_eop_q, slot_eop_d;
  rx_beat_t          out_q, out_d;
  logic              out_vld_q, out_vld_d;

  logic              ram_we_c, ram_re_c;
  logic [BYTE_W-1:0] ram_rdata;
  logic              buf_full_c, lf_full_c, end_c, drop_inc_c;
  logic              lf_push_c, lf_pop_c;
  logic              acc_c, load_out_c, slot_free_c;
  logic              issue_sop_c, issue_eop_c;
  logic [LEN_W-1:0]  lf_head_c;

  gig_eth_sdp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (BYTE_W)
  ) u_ram (
    .clk     (rx_clk),
    .wr_en   (ram_we_c),
    .wr_addr (wr_cur_q[ADDR_W-1:0]),
    .wr_data (mac_rx_data),
    .rd_en   (ram_re_c),
    .rd_addr (rd_iss_q[ADDR_W-1:0]),
    .rd_data (ram_rdata)
  );

  // The frame being sent still holds a slot, so LEN_DEPTH bounds all outstanding frames.
  assign buf_full_c = (wr_cur_q - rd_ptr_q) == BUF_BYTES;
  assign lf_full_c  = (lf_cnt_q + LF_CW'(r_state_q == R_SEND)) >= LF_SLOTS;
  assign end_c      = mac_rx_goodframe | mac_rx_badframe;
  assign lf_head_c  = lf_mem_q[lf_rd_q];

  // Write side: speculative store, commit or roll back on the end pulse.
  always_comb begin
    w_state_d   = w_state_q;
    wr_cur_d    = wr_cur_q;
    wr_com_d    = wr_com_q;
    frm_len_d   = frm_len_q;
    drop_cnt_d  = drop_cnt_q;
    dvld_prev_d = mac_rx_dvld;
    ram_we_c    = 1'b0;
    lf_push_c   = 1'b0;
    drop_inc_c  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (mac_rx_dvld && !dvld_prev_q) begin
          if (buf_full_c) begin
            w_state_d = W_DROP;
          end else begin
            ram_we_c  = 1'b1;
            wr_cur_d  = wr_cur_q + PTR_W'(1);
            frm_len_d = LEN_W'(1);
            w_state_d = W_RECV;
          end
        end
      end
      W_RECV: begin
        if (end_c) begin
          w_state_d = W_IDLE;
          if (!mac_rx_badframe && !lf_full_c) begin
            wr_com_d  = wr_cur_q;
            lf_push_c = 1'b1;
          end else begin
            wr_cur_d   = wr_com_q;
            drop_inc_c = 1'b1;
          end
        end else if (mac_rx_dvld) begin
          if (buf_full_c || (frm_len_q >= MAX_LEN)) begin
            w_state_d = W_DROP;
          end else begin
            ram_we_c  = 1'b1;
            wr_cur_d  = wr_cur_q + PTR_W'(1);
            frm_len_d = frm_len_q + LEN_W'(1);
          end
        end
      end
      W_DROP: begin
        if (end_c) begin
          w_state_d  = W_IDLE;
          wr_cur_d   = wr_com_q;
          drop_inc_c = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    if (drop_inc_c && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_W'(1);
  end

  // Length FIFO of committed frames.
  always_comb begin
    lf_mem_d = lf_mem_q;
    lf_wr_d  = lf_wr_q;
    lf_rd_d  = lf_rd_q;
    lf_cnt_d = lf_cnt_q;
    if (lf_push_c) begin
      lf_mem_d[lf_wr_q] = frm_len_q;
      lf_wr_d = (lf_wr_q == LF_LAST) ? '0 : lf_wr_q + LF_AW'(1);
    end
    if (lf_pop_c) lf_rd_d = (lf_rd_q == LF_LAST) ? '0 : lf_rd_q + LF_AW'(1);
    case ({lf_push_c, lf_pop_c})
      2'b10:   lf_cnt_d = lf_cnt_q + LF_CW'(1);
      2'b01:   lf_cnt_d = lf_cnt_q - LF_CW'(1);
      default: lf_cnt_d = lf_cnt_q;
    endcase
  end

  // Read side: RAM output register acts as a one-entry prefetch slot ahead of the output stage.
  assign acc_c       = out_vld_q & out_ready;
  assign load_out_c  = slot_vld_q & (~out_vld_q | out_ready);
  assign slot_free_c = ~slot_vld_q | load_out_c;

  always_comb begin
    r_state_d   = r_state_q;
    rd_left_d   = rd_left_q;
    rd_iss_d    = rd_iss_q;
    lf_pop_c    = 1'b0;
    ram_re_c    = 1'b0;
    issue_sop_c = 1'b0;
    issue_eop_c = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (lf_cnt_q != '0) begin
          lf_pop_c    = 1'b1;
          ram_re_c    = 1'b1;
          issue_sop_c = 1'b1;
          issue_eop_c = (lf_head_c == LEN_W'(1));
          rd_left_d   = lf_head_c - LEN_W'(1);
          rd_iss_d    = rd_iss_q + PTR_W'(1);
          r_state_d   = R_SEND;
        end
      end
      R_SEND: begin
        if ((rd_left_q != '0) && slot_free_c) begin
          ram_re_c    = 1'b1;
          issue_eop_c = (rd_left_q == LEN_W'(1));
          rd_left_d   = rd_left_q - LEN_W'(1);
          rd_iss_d    = rd_iss_q + PTR_W'(1);
        end
        if (acc_c && out_q.eop) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase

    slot_vld_d = ram_re_c | (slot_vld_q & ~load_out_c);
    slot_sop_d = ram_re_c ? issue_sop_c : slot_sop_q;
    slot_eop_d = ram_re_c ? issue_eop_c : slot_eop_q;
    out_vld_d  = load_out_c | (out_vld_q & ~out_ready);
    out_d      = out_q;
    if (load_out_c) out_d = '{sop: slot_sop_q, eop: slot_eop_q, data: ram_rdata};
    rd_ptr_d   = rd_ptr_q + PTR_W'(acc_c);
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      wr_cur_q    <= '0;
      wr_com_q    <= '0;
      rd_ptr_q    <= '0;
      rd_iss_q    <= '0;
      frm_len_q   <= '0;
      rd_left_q   <= '0;
      drop_cnt_q  <= '0;
      dvld_prev_q <= 1'b1;
      for (int i = 0; i < int'(LEN_DEPTH); i++) lf_mem_q[i] <= '0;
      lf_wr_q     <= '0;
      lf_rd_q     <= '0;
      lf_cnt_q    <= '0;
      slot_vld_q  <= 1'b0;
      slot_sop_q  <= 1'b0;
      slot_eop_q  <= 1'b0;
      out_q       <= '0;
      out_vld_q   <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      wr_cur_q    <= wr_cur_d;
      wr_com_q    <= wr_com_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_iss_q    <= rd_iss_d;
      frm_len_q   <= frm_len_d;
      rd_left_q   <= rd_left_d;
      drop_cnt_q  <= drop_cnt_d;
      dvld_prev_q <= dvld_prev_d;
      lf_mem_q    <= lf_mem_d;
      lf_wr_q     <= lf_wr_d;
      lf_rd_q     <= lf_rd_d;
      lf_cnt_q    <= lf_cnt_d;
      slot_vld_q  <= slot_vld_d;
      slot_sop_q  <= slot_sop_d;
      slot_eop_q  <= slot_eop_d;
      out_q       <= out_d;
      out_vld_q   <= out_vld_d;
    end
  end

  assign out_data  = out_q.data;
  assign out_sop   = out_q.sop;
  assign out_eop   = out_q.eop;
  assign out_valid = out_vld_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_gig_eth_rx_frame_buf.sv
// Scoreboard bench for the receive frame buffer: stimulus pushes expected
// beats, a negedge monitor pops and compares every accepted output byte.
module tb_gig_eth_rx_frame_buf;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } exp_t;

  logic        rx_clk = 1'b0;
  logic        reset_n;
  logic [7:0]  mac_rx_data;
  logic        mac_rx_dvld;
  logic        mac_rx_goodframe;
  logic        mac_rx_badframe;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sop;
  logic        out_eop;
  logic        out_ready;
  logic [15:0] drop_cnt;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        rand_rdy_en = 1'b0;
  logic        stall_q = 1'b0;
  logic [7:0]  held_data;
  logic        held_sop, held_eop;

  gig_eth_rx_frame_buf dut (
    .rx_clk           (rx_clk),
    .reset_n          (reset_n),
    .mac_rx_data      (mac_rx_data),
    .mac_rx_dvld      (mac_rx_dvld),
    .mac_rx_goodframe (mac_rx_goodframe),
    .mac_rx_badframe  (mac_rx_badframe),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_sop          (out_sop),
    .out_eop          (out_eop),
    .out_ready        (out_ready),
    .drop_cnt         (drop_cnt)
  );

  always #5 rx_clk = ~rx_clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int len, input logic [7:0] seed);
    for (int i = 0; i < len; i++)
      exp_q.push_back('{data: seed + 8'(i), sop: (i == 0), eop: (i == len - 1)});
  endtask

  // endk: 0 goodframe, 1 badframe, 2 both pulses
  task automatic send_frame(input int len, input logic [7:0] seed, input int endk);
    for (int i = 0; i < len; i++) begin
      @(posedge rx_clk); #1;
      mac_rx_dvld = 1'b1;
      mac_rx_data = seed + 8'(i);
    end
    @(posedge rx_clk); #1;
    mac_rx_dvld      = 1'b0;
    mac_rx_goodframe = (endk == 0) || (endk == 2);
    mac_rx_badframe  = (endk == 1) || (endk == 2);
    @(posedge rx_clk); #1;
    mac_rx_goodframe = 1'b0;
    mac_rx_badframe  = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int bound);
    for (int c = 0; c < bound; c++) begin
      @(negedge rx_clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check(name, exp_q.size(), 0);
    @(posedge rx_clk); #1;
  endtask

  // Monitor: compare accepted beats and hold-stability during stalls.
  always @(negedge rx_clk) begin
    if (!reset_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        n_checks++;
        if (!out_valid || out_data !== held_data || out_sop !== held_sop || out_eop !== held_eop) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%0d data=%02h sop=%0d eop=%0d expected v=1 data=%02h sop=%0d eop=%0d",
                   out_valid, out_data, out_sop, out_eop, held_data, held_sop, held_eop);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat: got unexpected data=%02h sop=%0d eop=%0d expected no output",
                   out_data, out_sop, out_eop);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (out_data !== e.data || out_sop !== e.sop || out_eop !== e.eop) begin
            n_fail++;
            $display("FAIL beat: got data=%02h sop=%0d eop=%0d expected data=%02h sop=%0d eop=%0d",
                     out_data, out_sop, out_eop, e.data, e.sop, e.eop);
          end
        end
      end
      stall_q   = out_valid && !out_ready;
      held_data = out_data;
      held_sop  = out_sop;
      held_eop  = out_eop;
    end
  end

  always @(posedge rx_clk) begin
    if (rand_rdy_en) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n          = 1'b0;
    mac_rx_data      = 8'h00;
    mac_rx_dvld      = 1'b0;
    mac_rx_goodframe = 1'b0;
    mac_rx_badframe  = 1'b0;
    out_ready        = 1'b1;
    repeat (3) @(posedge rx_clk);
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_data",  int'(out_data), 0);
    check("rst_sop",   int'(out_sop), 0);
    check("rst_eop",   int'(out_eop), 0);
    check("rst_drop",  int'(drop_cnt), 0);
    reset_n = 1'b1;
    repeat (2) @(posedge rx_clk);
    #1;

    // 64-byte good frame with latency check
    push_exp(64, 8'h10);
    send_frame(64, 8'h10, 0);
    @(negedge rx_clk);
    @(negedge rx_clk);
    check("lat_before", int'(out_valid), 0);
    @(negedge rx_clk);
    check("lat_first", int'(out_valid), 1);
    @(posedge rx_clk); #1;
    wait_drain("drain_64", 500);
    check("drop_64", int'(drop_cnt), 0);

    // bad frame rolled back, then a good frame from the same space
    send_frame(100, 8'hA0, 1);
    check("drop_bad", int'(drop_cnt), 1);
    push_exp(60, 8'h55);
    send_frame(60, 8'h55, 0);
    wait_drain("drain_60", 500);
    check("drop_after60", int'(drop_cnt), 1);

    // oversize frame
    send_frame(1600, 8'h00, 0);
    check("drop_oversize", int'(drop_cnt), 2);
    repeat (20) @(posedge rx_clk);
    #1;
    check("oversize_quiet", int'(out_valid), 0);

    // five frames with the consumer stalled; only four fit
    out_ready = 1'b0;
    for (int f = 0; f < 5; f++) begin
      if (f < 4) push_exp(64, 8'(8'h20 * f + 8'h03));
      send_frame(64, 8'(8'h20 * f + 8'h03), 0);
    end
    check("drop_fifth", int'(drop_cnt), 3);
    check("stalled_valid", int'(out_valid), 1);
    check("stalled_sop", int'(out_sop), 1);
    out_ready = 1'b1;
    wait_drain("drain_four", 1500);

    // random backpressure on a 1518-byte frame
    push_exp(1518, 8'h7B);
    rand_rdy_en = 1'b1;
    send_frame(1518, 8'h7B, 0);
    wait_drain("drain_1518", 12000);
    rand_rdy_en = 1'b0;
    @(posedge rx_clk); #1;
    out_ready = 1'b1;
    check("drop_1518", int'(drop_cnt), 3);

    // reset in the middle of a frame while another frame is stalled at the output
    out_ready = 1'b0;
    push_exp(20, 8'h30);
    send_frame(20, 8'h30, 0);
    repeat (4) @(posedge rx_clk);
    #1;
    check("pre_rst_valid", int'(out_valid), 1);
    for (int i = 0; i < 30; i++) begin
      @(posedge rx_clk); #1;
      mac_rx_dvld = 1'b1;
      mac_rx_data = 8'hC0 + 8'(i);
    end
    @(posedge rx_clk); #1;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_data", int'(out_data), 0);
    check("midrst_sop", int'(out_sop), 0);
    check("midrst_drop", int'(drop_cnt), 0);
    repeat (3) @(posedge rx_clk);
    #1;
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge rx_clk); #1;
      mac_rx_data = 8'hE0 + 8'(i);
    end
    @(posedge rx_clk); #1;
    mac_rx_dvld      = 1'b0;
    mac_rx_goodframe = 1'b1;
    @(posedge rx_clk); #1;
    mac_rx_goodframe = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge rx_clk);
    #1;
    check("tail_ignored_drop", int'(drop_cnt), 0);
    check("tail_ignored_valid", int'(out_valid), 0);
    push_exp(64, 8'h91);
    send_frame(64, 8'h91, 0);
    wait_drain("drain_post_rst", 500);

    // single-byte frame carries sop and eop together
    push_exp(1, 8'h5A);
    send_frame(1, 8'h5A, 0);
    wait_drain("drain_1byte", 100);

    // simultaneous good and bad pulses count as bad
    send_frame(10, 8'h44, 2);
    check("drop_both", int'(drop_cnt), 1);
    repeat (10) @(posedge rx_clk);
    #1;
    check("both_quiet", int'(out_valid), 0);

    check("final_queue", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gig_eth_rx_frame_buf.md
GIG_ETH_RX_FRAME_BUF -- requirements
Module: gig_eth_rx_frame_buf

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning a data buffer of 2^ADDR_W bytes (2048).
REQ-002 SHALL have parameter LEN_DEPTH, default 4, meaning the maximum number of committed frames queued.
REQ-003 SHALL have parameter MAX_FRAME, default 1522, meaning the largest accepted frame in bytes.
REQ-004 SHALL have port rx_clk, input, 1 bit: the single clock; all logic is in this domain.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port mac_rx_data, input, 8 bits: byte from the MAC receiver.
REQ-007 SHALL have port mac_rx_dvld, input, 1 bit: mac_rx_data valid this cycle.
REQ-008 SHALL have port mac_rx_goodframe, input, 1 bit: one-cycle pulse after the last byte; frame OK.
REQ-009 SHALL have port mac_rx_badframe, input, 1 bit: one-cycle pulse after the last byte; frame bad.
REQ-010 SHALL have port out_data, output, 8 bits: buffered frame byte.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data valid.
REQ-012 SHALL have port out_sop, output, 1 bit: first byte of a frame.
REQ-013 SHALL have port out_eop, output, 1 bit: last byte of a frame.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer accepts the byte.
REQ-015 SHALL have port drop_cnt, output, 16 bits: saturating count of discarded frames.

Function
REQ-016 SHALL be store-and-forward: a frame is emitted only after mac_rx_goodframe commits it; bad frames are never emitted.
REQ-017 Write FSM SHALL have states W_IDLE, W_RECV and W_DROP.
 - W_IDLE -> W_RECV on mac_rx_dvld; the first byte is written.
 - W_RECV -> W_DROP when the buffer is full, or when the byte count would exceed MAX_FRAME; the offending byte is discarded.
 - W_RECV or W_DROP -> W_IDLE on an end pulse.
REQ-018 Write pointer wr_cur (ADDR_W+1 bits) SHALL advance per stored byte; full is (wr_cur - rd_ptr) == 2^ADDR_W; pointers wrap modulo 2^(ADDR_W+1).
REQ-019 On goodframe in W_RECV with the length FIFO not full, SHALL commit: wr_com <= wr_cur, and push the length (14 bits) into the length FIFO.
REQ-020 On badframe, on goodframe in W_DROP, or on goodframe with the length FIFO full, SHALL roll back wr_cur <= wr_com and increment drop_cnt, saturating at 0xFFFF.
REQ-021 goodframe and badframe in the same cycle SHALL be treated as badframe.
REQ-022 An end pulse in W_IDLE (zero-byte frame) SHALL be ignored; no commit, no drop count.
REQ-023 Read FSM SHALL have states R_IDLE and R_SEND.
 - R_IDLE -> R_SEND when the length FIFO is non-empty; the length is popped and the first RAM read is issued.
 - R_SEND -> R_IDLE on acceptance of the eop byte.
REQ-024 RAM read latency SHALL be 1 cycle; the first out_valid rises 2 cycles after the length FIFO becomes non-empty.
REQ-025 While out_valid=1 and out_ready=0, out_data, out_sop and out_eop SHALL hold stable.
REQ-026 In R_SEND, SHALL sustain 1 byte per cycle while out_ready=1 (prefetch or skid register).
REQ-027 rd_ptr SHALL advance per accepted byte; freed space is visible to the write side the next cycle.
REQ-028 A frame committed in cycle N SHALL be visible to the read FSM no earlier than cycle N+1.
REQ-029 A 1-byte frame SHALL assert out_sop and out_eop together.
REQ-030 Simultaneous write and read in the same cycle SHALL both proceed; the read side only reads below wr_com.

Reset
REQ-031 On reset_n=0 (asynchronous), SHALL clear all pointers, the length FIFO and drop_cnt, and enter W_IDLE and R_IDLE.
REQ-032 During reset, out_valid, out_sop and out_eop SHALL be 0 and out_data SHALL be 0x00; RAM contents are not reset.
REQ-033 A reset asserted mid-frame SHALL discard all buffered and partial frames; after release, reception resumes at the next mac_rx_dvld rising from W_IDLE.

Structure
REQ-034 Shared package gig_eth_pkg SHALL hold MAX_FRAME_SIZE_STANDARD (1522), MAX_FRAME_SIZE_JUMBO (9022) and the FSM state encodings.
REQ-035 SHALL instantiate one sub-module gig_eth_sdp_ram: simple dual-port, 8-bit wide, 2^ADDR_W deep, registered read.
REQ-036 The length FIFO SHALL be inline registers, not a separate module.

Verification
REQ-037 Send a 64-byte frame, then goodframe, with out_ready=1 -> the same 64 bytes out; sop on byte 0, eop on byte 63; drop_cnt=0.
REQ-038 Send a 100-byte frame, then badframe -> no output; drop_cnt=1; the next 60-byte good frame is output intact from the rolled-back pointer.
REQ-039 Send a 1600-byte frame, then goodframe -> dropped; drop_cnt increments; no output.
REQ-040 Send five 64-byte good frames with out_ready=0 -> the first four are queued and the fifth is dropped (drop_cnt=1); releasing out_ready yields 4 frames.
REQ-041 Toggle out_ready randomly on a 1518-byte frame -> data is held stable during stalls and the byte sequence is exact.
REQ-042 Assert reset_n=0 at byte 30 of a frame -> out_valid=0 immediately; a post-reset 64-byte frame passes correctly.
